mac_accumulator: RTL
====================

Name: mac_accumulator

Overview:
- Downstream stage of the registered signed multiplier. Consumes its 2N-bit signed products and sums a programmed number of them into a wide accumulator.
- Presents the final sum through a valid/ready output handshake.
- Drives the multiplier's enable (through prod_ready) so the multiplier stalls while the accumulator is idle or holding a result.
- Target use: dot-product / FIR-tap summation.

Parameters:
- N, 32, multiplier operand width; the product width is 2*N.
- GUARD, 8, extra accumulator bits above 2*N; ACC_W = 2*N + GUARD.
- CNT_W, 16, width of the term-count input and the internal counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a new accumulation; honoured only in IDLE.
- len  input  CNT_W  number of products to sum; sampled when start is accepted.
- prod_in  input  2*N  signed product from the multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  accumulator accepts a product; also drives the multiplier's en.
- acc_out  output  ACC_W  signed accumulated result.
- acc_valid  output  1  acc_out holds a final result.
- acc_ready  input  1  downstream accepts acc_out.
- busy  output  1  high in ACCUM or DONE.
- overflow  output  1  sticky flag: an addition exceeded the ACC_W signed range during the current job.

Behaviour:
- Reset (asynchronous): state=IDLE; acc=0; remaining=0; overflow=0; outputs are prod_ready=0, acc_valid=0, busy=0, acc_out=0.
- Reset asserted mid-operation aborts the job immediately. No partial result is emitted.
- State IDLE:
  - prod_ready=0.
  - start=1 and len!=0: acc<=0, remaining<=len, overflow<=0, go to ACCUM.
  - start=1 and len==0: acc<=0, overflow<=0, go to DONE. acc_valid rises the next cycle with result 0.
- State ACCUM:
  - prod_ready=1 (combinational from state only; not dependent on prod_valid).
  - A product is accepted on a cycle with prod_valid & prod_ready.
  - On accept: acc <= acc + sign_extend(prod_in to ACC_W); remaining <= remaining-1.
  - If remaining==1 at accept, go to DONE. acc_valid is asserted the cycle after the last accepted product (latency 1).
  - Cycles with prod_valid=0 leave acc and remaining unchanged.
- State DONE:
  - acc_valid=1 and prod_ready=0. acc_out stays stable while acc_ready=0.
  - acc_valid & acc_ready: go to IDLE. acc_out keeps its last value; acc_valid falls the next cycle.
- start is ignored in ACCUM and DONE. No queuing.
- start and a handshake in the same cycle: the handshake completes first. start is ignored that cycle because the block is not yet in IDLE.
- Overflow detection: both operands have the same sign and the raw sum has a different sign. On detection, set overflow (sticky until the next accepted start).
- Without saturation, the sum wraps modulo 2^ACC_W.
- acc_out is a direct register output. No combinational path from prod_in to acc_out.

Optional Feature:
- Macro: MAC_ACCUMULATOR_SAT_EN.
- Defined: on overflow, acc is clamped to the most positive value (2^(ACC_W-1)-1) or most negative value (-2^(ACC_W-1)), matching the operand sign. overflow is still set. Later additions start from the clamped value.
- Undefined: two's-complement wrap; overflow flag only.

Decomposition:
- Shared package mac_pkg:
  - State enum {IDLE, ACCUM, DONE}, 2 bits.
  - Default widths: N=32, GUARD=8, CNT_W=16.
  - ACC_W derivation function.
  - Saturation constant functions acc_max/acc_min.
- One natural sub-module: mac_sat_add. It is combinational: signed ACC_W add, overflow detect, and optional clamp under the macro. The top level holds the FSM, counter and registers.

Test Plan:
- Basic sum: start, len=3; products 10, -3, 7 on consecutive cycles with acc_ready=1 -> acc_valid one cycle after the third product, acc_out=14, overflow=0, prod_ready low in DONE.
- len=0: start with len=0 -> next cycle acc_valid=1, acc_out=0, no products consumed (prod_ready stays 0).
- Upstream gaps and downstream backpressure: len=4, products 1,2,3,4 with prod_valid idle for 2 cycles between each; hold acc_ready=0 for 5 cycles -> acc_out=10 stable, acc_valid held; start pulses during DONE ignored; IDLE after handshake.
- Overflow (GUARD=0, N=4, ACC_W=8): len=2, products 100, 100:
  - Without macro: acc_out=-56 (200 wrapped), overflow=1.
  - With MAC_ACCUMULATOR_SAT_EN: acc_out=127, overflow=1.
  - Next start clears overflow.
- Negative saturation (same config, macro on): products -100, -100 -> acc_out=-128, overflow=1.
- Reset mid-job: len=5, assert reset asynchronously after 2 products -> outputs go to 0 immediately without waiting for a clock edge, state IDLE. A new job with len=1, product -7 -> acc_out=-7.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types, default widths and constant helpers for the
// MAC accumulator slice (mac_accumulator, mac_sat_add).
//   mac_state_e       : controller state {IDLE, ACCUM, DONE}
//   DEF_N/GUARD/CNT_W : default operand, guard and counter widths
//   acc_w()           : accumulator width from operand width and guard bits
//   acc_max/acc_min() : saturation limits, returned LSB-aligned in a wide
//                       vector; callers truncate to their accumulator width.
package mac_pkg;

    localparam int unsigned DEF_N       = 32;
    localparam int unsigned DEF_GUARD   = 8;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned SAT_CONST_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

    function automatic int unsigned acc_w(input int unsigned n, input int unsigned guard);
        return 2 * n + guard;
    endfunction

    // Most positive signed value of a w-bit accumulator: 0111...1.
    function automatic logic [SAT_CONST_W-1:0] acc_max(input int unsigned w);
        return (SAT_CONST_W'(1) << (w - 1)) - SAT_CONST_W'(1);
    endfunction

    // Most negative signed value of a w-bit accumulator: 1000...0 once truncated to w bits.
    function automatic logic [SAT_CONST_W-1:0] acc_min(input int unsigned w);
        return SAT_CONST_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: combinational signed W-bit adder with overflow detection.
// Configuration macro: MAC_ACCUMULATOR_SAT_EN
//   defined   -> an overflowing sum clamps to the extreme matching the operand sign
//   undefined -> two's-complement wrap; overflow is only reported
// Ports:
//   i_a, i_b  : signed W-bit operands
//   o_sum_c   : sum (wrapped or clamped)
//   o_ovf_c   : signed overflow of the raw sum
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int unsigned W = 72
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum_c,
    output logic         o_ovf_c
);

    logic [W-1:0] w_raw;

    assign w_raw   = i_a + i_b;
    // Like-signed operands producing an opposite-signed result.
    assign o_ovf_c = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);

`ifdef MAC_ACCUMULATOR_SAT_EN
    localparam logic [W-1:0] SAT_MAX = W'(acc_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(acc_min(W));

    // Both operands share a sign on overflow, so i_a's sign selects the rail.
    assign o_sum_c = o_ovf_c ? (i_a[W-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
    assign o_sum_c = w_raw;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmed number of signed 2N-bit products from
// the upstream multiplier into an ACC_W = 2N+GUARD bit accumulator and
// returns the total through a valid/ready handshake.
// Configuration macro: MAC_ACCUMULATOR_SAT_EN (clamp on overflow instead of wrap).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start, len            : job start pulse (IDLE only) and term count
//   prod_in, prod_valid   : product stream from the multiplier
//   prod_ready            : product accepted this cycle; also the multiplier enable
//   acc_out, acc_valid    : registered result and its valid
//   acc_ready             : downstream accepts the result
//   busy                  : job in progress or result pending
//   overflow              : sticky signed-overflow flag for the current job
module mac_accumulator
    import mac_pkg::*;
#(
    parameter  int unsigned N     = DEF_N,
    parameter  int unsigned GUARD = DEF_GUARD,
    parameter  int unsigned CNT_W = DEF_CNT_W,
    localparam int unsigned P_W   = 2 * N,
    localparam int unsigned ACC_W = acc_w(N, GUARD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [P_W-1:0]   prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             overflow
);

    mac_state_e       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_remaining;
    logic             r_overflow;
    logic             r_prod_ready;
    logic             r_acc_valid;
    logic             r_busy;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;
    logic             w_accept;

    // Signed cast sign-extends the product; also valid when GUARD is zero.
    assign w_prod_ext = ACC_W'($signed(prod_in));
    assign w_accept   = prod_valid & r_prod_ready;

    mac_sat_add #(
        .W (ACC_W)
    ) u_sat_add (
        .i_a     (r_acc),
        .i_b     (w_prod_ext),
        .o_sum_c (w_sum),
        .o_ovf_c (w_ovf)
    );

    // Controller, term counter and accumulator; handshake outputs move with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_remaining  <= '0;
            r_overflow   <= 1'b0;
            r_prod_ready <= 1'b0;
            r_acc_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc      <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        if (len != '0) begin
                            r_remaining  <= len;
                            r_prod_ready <= 1'b1;
                            r_state      <= ACCUM;
                        end else begin
                            r_acc_valid <= 1'b1;
                            r_state     <= DONE;
                        end
                    end
                end

                ACCUM: begin
                    if (w_accept) begin
                        r_acc       <= w_sum;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_ovf) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_remaining == CNT_W'(1)) begin
                            r_prod_ready <= 1'b0;
                            r_acc_valid  <= 1'b1;
                            r_state      <= DONE;
                        end
                    end
                end

                DONE: begin
                    // start is not looked at here, even alongside the handshake.
                    if (acc_ready) begin
                        r_acc_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_prod_ready <= 1'b0;
                    r_acc_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign prod_ready = r_prod_ready;
    assign acc_out    = r_acc;
    assign acc_valid  = r_acc_valid;
    assign busy       = r_busy;
    assign overflow   = r_overflow;

endmodule
